// File: rtl/rvm_muldiv_iter.sv
// Iterative RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Define MULDIV_HW_MULTIPLY_EN to compute multiplies with one combinational multiplier in PREP.
module rvm_muldiv_iter #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      operation_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            div_zero_o
);

  localparam int N     = XLEN / STEP_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [XLEN-1:0]     a_reg, b_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                neg_q_reg, neg_r_reg, special_reg, dz_reg;
  logic [XLEN-1:0]     result_reg;
  logic                div_zero_reg;

  // Operand decode, evaluated in PREP from the latched request
  logic            is_div, op1_signed, op2_signed, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b, special_val;
  logic            div_by_zero, overflow, special, skip_calc;

  assign is_div     = op_reg[2];
  assign op1_signed = op_reg[2] ? ~op_reg[0] : (op_reg[1:0] == 2'b01 || op_reg[1:0] == 2'b10);
  assign op2_signed = op_reg[2] ? ~op_reg[0] : (op_reg[1:0] == 2'b01);
  assign neg_a      = op1_signed & a_reg[XLEN-1];
  assign neg_b      = op2_signed & b_reg[XLEN-1];
  assign abs_a      = neg_a ? -a_reg : a_reg;
  assign abs_b      = neg_b ? -b_reg : b_reg;
  assign div_by_zero = is_div & (b_reg == '0);
  assign overflow    = is_div & ~op_reg[0] & (a_reg == {1'b1, {(XLEN-1){1'b0}}}) & (&b_reg);
  assign special     = div_by_zero | overflow;

  always_comb begin
    special_val = '0;
    if (div_by_zero)
      special_val = op_reg[1] ? a_reg : '1;
    else if (overflow)
      special_val = op_reg[1] ? '0 : a_reg;
  end

  // Restoring division: acc holds {remainder, dividend/quotient}, b_reg the divisor
  logic [2*XLEN-1:0] div_chain [STEP_BITS+1];
  assign div_chain[0] = acc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STEP_BITS; gi++) begin : g_div
      logic [XLEN:0] shifted, diff;
      assign shifted = {div_chain[gi][2*XLEN-1:XLEN], div_chain[gi][XLEN-1]};
      assign diff    = shifted - {1'b0, b_reg};
      assign div_chain[gi+1] = diff[XLEN]
          ? {shifted[XLEN-1:0], div_chain[gi][XLEN-2:0], 1'b0}
          : {diff[XLEN-1:0],    div_chain[gi][XLEN-2:0], 1'b1};
    end
  endgenerate

  logic [2*XLEN-1:0] step_next;

`ifdef MULDIV_HW_MULTIPLY_EN
  logic [2*XLEN-1:0] hw_prod;
  assign hw_prod   = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
  assign step_next = div_chain[STEP_BITS];
  assign skip_calc = special | ~is_div;
`else
  // Shift-add: multiplier in the low half shifts out as the product grows in from the top
  logic [2*XLEN-1:0] mul_chain [STEP_BITS+1];
  assign mul_chain[0] = acc_reg;
  generate
    for (gi = 0; gi < STEP_BITS; gi++) begin : g_mul
      logic [XLEN:0] sum;
      assign sum = {1'b0, mul_chain[gi][2*XLEN-1:XLEN]} +
                   (mul_chain[gi][0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
      assign mul_chain[gi+1] = {sum, mul_chain[gi][XLEN-1:1]};
    end
  endgenerate
  assign step_next = is_div ? div_chain[STEP_BITS] : mul_chain[STEP_BITS];
  assign skip_calc = special;
`endif

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot_fixed, rem_fixed, fix_result;

  assign prod_fixed = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fixed = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fixed  = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    if (special_reg)
      fix_result = acc_reg[XLEN-1:0];
    else if (is_div)
      fix_result = op_reg[1] ? rem_fixed : quot_fixed;
    else if (op_reg[1:0] == 2'b00)
      fix_result = prod_fixed[XLEN-1:0];
    else
      fix_result = prod_fixed[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (flush_i)
      state_next = S_IDLE;
    else begin
      case (state_reg)
        S_IDLE: if (valid_i) state_next = S_PREP;
        S_PREP: state_next = skip_calc ? S_FIX : S_CALC;
        S_CALC: if (cnt_reg == CNT_W'(N-1)) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (ready_i) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    ready_o    = (state_reg == S_IDLE);
    valid_o    = (state_reg == S_DONE);
    result_o   = result_reg;
    div_zero_o = div_zero_reg;
  end

  // Datapath
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      special_reg  <= 1'b0;
      dz_reg       <= 1'b0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else if (flush_i) begin
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (valid_i) begin
            op_reg <= operation_i;
            a_reg  <= operand1_i;
            b_reg  <= operand2_i;
          end
        end
        S_PREP: begin
          b_reg       <= abs_b;
          neg_q_reg   <= neg_a ^ neg_b;
          neg_r_reg   <= neg_a;
          special_reg <= special;
          dz_reg      <= div_by_zero;
          cnt_reg     <= '0;
          if (special)
            acc_reg <= {{XLEN{1'b0}}, special_val};
`ifdef MULDIV_HW_MULTIPLY_EN
          else if (!is_div)
            acc_reg <= hw_prod;
`endif
          else
            acc_reg <= {{XLEN{1'b0}}, abs_a};
        end
        S_CALC: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_FIX: begin
          result_reg   <= fix_result;
          div_zero_reg <= dz_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
